// File: rtl/pacman_mover.sv
// Pac-Man tile mover: wall-map lookup, buffered turn request, and a three-phase tick FSM.
// Optional define PACMAN_TURN_EXPIRE_EN drops a pending turn after TURN_HOLD_TICKS unused ticks.
module pacman_mover #(
    parameter int MAP_COLS        = 32,
    parameter int ROW_AW          = 5,
    parameter int MAP_ROWS        = 24,
    parameter int START_X         = 15,
    parameter int START_Y         = 20,
    parameter int START_DIR       = 1,
    parameter int TURN_HOLD_TICKS = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             move_tick,
    input  logic                             freeze,
    input  logic                             dir_valid,
    input  logic [1:0]                       dir_req,
    output logic [2:0][ROW_AW-1:0]           map_addr,
    input  logic [2:0][MAP_COLS-1:0]         map_row,
    output logic [$clog2(MAP_COLS)-1:0]      pos_x,
    output logic [ROW_AW-1:0]                pos_y,
    output logic [1:0]                       cur_dir,
    output logic                             moving,
    output logic                             blocked,
    output logic                             step_done
);

    localparam int XW = $clog2(MAP_COLS);

    typedef enum logic [1:0] {IDLE, EVAL, UPDATE} state_t;
    typedef enum logic [1:0] {DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT} dir_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   pos_x_q, pos_x_d;
    logic [ROW_AW-1:0] pos_y_q, pos_y_d;
    dir_t            cur_dir_q, cur_dir_d;
    logic            moving_q, moving_d;
    logic            blocked_q, blocked_d;
    logic            step_done_q, step_done_d;
    logic            pending_valid_q, pending_valid_d;
    dir_t            pending_dir_q, pending_dir_d;
    logic [3:0]      open_q, open_d;

`ifdef PACMAN_TURN_EXPIRE_EN
    localparam int CW = $clog2(TURN_HOLD_TICKS + 1);
    logic [CW-1:0]   hold_cnt_q, hold_cnt_d;
`endif

    logic [XW-1:0]   x_right, x_left;
    logic            open_up, open_right, open_down, open_left;
    logic            consume;
    dir_t            step_dir;

    // Column 0 sits in the MSB of each ROM row.
    function automatic logic is_wall(input logic [MAP_COLS-1:0] row, input logic [XW-1:0] col);
        logic [MAP_COLS-1:0] rev;
        for (int unsigned i = 0; i < MAP_COLS; i++) rev[i] = row[MAP_COLS-1-i];
        return rev[col];
    endfunction

    always_comb begin
        map_addr[1] = pos_y_q;
        map_addr[0] = (pos_y_q == '0) ? ROW_AW'(MAP_ROWS - 1) : pos_y_q - 1'b1;
        map_addr[2] = (pos_y_q == ROW_AW'(MAP_ROWS - 1)) ? '0 : pos_y_q + 1'b1;
    end

    always_comb begin
        x_right    = (pos_x_q == XW'(MAP_COLS - 1)) ? '0 : pos_x_q + 1'b1;
        x_left     = (pos_x_q == '0) ? XW'(MAP_COLS - 1) : pos_x_q - 1'b1;
        // Rows never wrap, so the map_addr wrap rows are masked off here.
        open_up    = (pos_y_q != '0) && !is_wall(map_row[0], pos_x_q);
        open_down  = (pos_y_q != ROW_AW'(MAP_ROWS - 1)) && !is_wall(map_row[2], pos_x_q);
        open_right = !is_wall(map_row[1], x_right);
        open_left  = !is_wall(map_row[1], x_left);
    end

    always_comb begin
        state_d         = state_q;
        pos_x_d         = pos_x_q;
        pos_y_d         = pos_y_q;
        cur_dir_d       = cur_dir_q;
        moving_d        = moving_q;
        blocked_d       = 1'b0;
        step_done_d     = 1'b0;
        pending_valid_d = pending_valid_q;
        pending_dir_d   = pending_dir_q;
        open_d          = open_q;
        consume         = pending_valid_q && open_q[pending_dir_q];
        step_dir        = consume ? pending_dir_q : cur_dir_q;
`ifdef PACMAN_TURN_EXPIRE_EN
        hold_cnt_d      = hold_cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (move_tick && !freeze) state_d = EVAL;
            end
            EVAL: begin
                // Bit index matches the direction encoding.
                open_d  = {open_left, open_down, open_right, open_up};
                state_d = UPDATE;
            end
            UPDATE: begin
                state_d = IDLE;
                if (consume || open_q[cur_dir_q]) begin
                    cur_dir_d   = step_dir;
                    moving_d    = 1'b1;
                    step_done_d = 1'b1;
                    case (step_dir)
                        DIR_UP:    pos_y_d = pos_y_q - 1'b1;
                        DIR_DOWN:  pos_y_d = pos_y_q + 1'b1;
                        DIR_RIGHT: pos_x_d = x_right;
                        DIR_LEFT:  pos_x_d = x_left;
                        default:   pos_x_d = pos_x_q;
                    endcase
                end else begin
                    moving_d  = 1'b0;
                    blocked_d = 1'b1;
                end
                if (consume) begin
                    pending_valid_d = 1'b0;
                end
`ifdef PACMAN_TURN_EXPIRE_EN
                else if (pending_valid_q && hold_cnt_q != '0) begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                    if (hold_cnt_q == CW'(1)) pending_valid_d = 1'b0;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        // A request arriving in EVAL lands before UPDATE reads it; one arriving in
        // UPDATE is newer than the evaluated one and must survive consumption.
        if (dir_valid) begin
            pending_valid_d = 1'b1;
            pending_dir_d   = dir_t'(dir_req);
`ifdef PACMAN_TURN_EXPIRE_EN
            hold_cnt_d      = CW'(TURN_HOLD_TICKS);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            pos_x_q         <= XW'(START_X);
            pos_y_q         <= ROW_AW'(START_Y);
            cur_dir_q       <= dir_t'(2'(START_DIR));
            moving_q        <= 1'b0;
            blocked_q       <= 1'b0;
            step_done_q     <= 1'b0;
            pending_valid_q <= 1'b0;
            pending_dir_q   <= DIR_UP;
            open_q          <= '0;
`ifdef PACMAN_TURN_EXPIRE_EN
            hold_cnt_q      <= '0;
`endif
        end else begin
            state_q         <= state_d;
            pos_x_q         <= pos_x_d;
            pos_y_q         <= pos_y_d;
            cur_dir_q       <= cur_dir_d;
            moving_q        <= moving_d;
            blocked_q       <= blocked_d;
            step_done_q     <= step_done_d;
            pending_valid_q <= pending_valid_d;
            pending_dir_q   <= pending_dir_d;
            open_q          <= open_d;
`ifdef PACMAN_TURN_EXPIRE_EN
            hold_cnt_q      <= hold_cnt_d;
`endif
        end
    end

    assign pos_x     = pos_x_q;
    assign pos_y     = pos_y_q;
    assign cur_dir   = cur_dir_q;
    assign moving    = moving_q;
    assign blocked   = blocked_q;
    assign step_done = step_done_q;

endmodule
